// File: rtl/pipe_pkg.sv
// Shared definitions for the RISC-V pipeline: opcode constants and the
// hazard/trap controller state encoding.
package pipe_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Load-use comparator: a load in EX whose destination feeds the ID instruction.
module hazard_cmp (
  input  logic       ex_v,
  input  logic       ex_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       id_valid,
  output logic       hazard
);

  // x0 never carries a real dependency, so a load to x0 cannot stall.
  assign hazard = id_valid && ex_v && ex_load && (ex_rd != 5'd0) &&
                  ((ex_rd == rs1) || (ex_rd == rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller beside ID: load-use stalls, control-transfer
// flushes, memory-wait freeze and the drain-then-redirect trap sequence.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_ill,
  input  logic [31:0] id_pc,
  input  logic        ex_redirect,
  input  logic        dmem_wait,
  output logic        if_en,
  output logic        id_en,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        trap_redirect,
  output logic [31:0] trap_epc,
  output logic        trap_busy
);

  ctrl_state_t state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        ex_v_reg, ex_load_reg;
  logic [4:0]  ex_rd_reg;
  logic [31:0] trap_epc_reg;
  logic        capture;
  logic        hazard;

  hazard_cmp u_hazard_cmp (
    .ex_v     (ex_v_reg),
    .ex_load  (ex_load_reg),
    .ex_rd    (ex_rd_reg),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .id_valid (id_valid),
    .hazard   (hazard)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    capture       = 1'b0;
    if_en         = 1'b1;
    id_en         = 1'b1;
    id_flush      = 1'b0;
    ex_flush      = 1'b0;
    trap_redirect = 1'b0;
    if (reset) begin
      if_en    = 1'b0;
      id_en    = 1'b0;
      id_flush = 1'b1;
      ex_flush = 1'b1;
    end else if (dmem_wait) begin
      if_en = 1'b0;
      id_en = 1'b0;
    end else if (ex_redirect) begin
      // The trapping instruction, if any, was on the wrong path.
      id_flush   = 1'b1;
      ex_flush   = 1'b1;
      state_next = RUN;
    end else begin
      unique case (state_reg)
        RUN: begin
          if (id_valid && id_ill) begin
            capture  = 1'b1;
            if_en    = 1'b0;
            id_en    = 1'b0;
            ex_flush = 1'b1;
            if (DRAIN_CYCLES > 1) begin
              cnt_next   = 3'(DRAIN_CYCLES - 1);
              state_next = DRAIN;
            end else begin
              state_next = REDIRECT;
            end
          end else if (hazard) begin
            if_en    = 1'b0;
            id_en    = 1'b0;
            ex_flush = 1'b1;
          end
        end
        DRAIN: begin
          if_en    = 1'b0;
          id_en    = 1'b0;
          ex_flush = 1'b1;
          cnt_next = cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) state_next = REDIRECT;
        end
        REDIRECT: begin
          trap_redirect = 1'b1;
          id_flush      = 1'b1;
          ex_flush      = 1'b1;
          state_next    = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      cnt_reg      <= 3'd0;
      ex_v_reg     <= 1'b0;
      ex_load_reg  <= 1'b0;
      ex_rd_reg    <= 5'd0;
      trap_epc_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) trap_epc_reg <= id_pc;
      // The EX shadow tracks ID/EX: it holds while frozen, bubbles on flush.
      if (!dmem_wait) begin
        if (ex_flush) begin
          ex_v_reg <= 1'b0;
        end else begin
          ex_v_reg    <= id_valid;
          ex_rd_reg   <= id_rd;
          ex_load_reg <= (id_opcode == OP_LOAD);
        end
      end
    end
  end

  assign trap_epc  = trap_epc_reg;
  assign trap_busy = (state_reg != RUN) && !reset;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It sits beside the ID stage and consumes the decoded fields (opcode, rs1, rs2, rd, ill) plus status from EX and data memory. It produces the per-stage enables and flushes: load-use stalls, control-transfer flushes, global freeze on data-memory wait, and a drain-then-redirect sequence for illegal instructions.

## Interface
Parameters:
- DRAIN_CYCLES, 2: older-instruction drain length (EX, MEM) before trap redirect; valid range 1..7.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  IF/ID register holds a real instruction
- id_opcode  in  7  decoded opcode
- id_rs1, id_rs2  in  5 each  source indices; 0 means unused
- id_rd  in  5  destination index; 0 means none
- id_ill  in  1  decoder flags an illegal instruction
- id_pc  in  32  PC of the ID instruction
- ex_redirect  in  1  EX resolved a taken BRANCH, JAL or JALR
- dmem_wait  in  1  data memory not ready; whole pipeline freezes
- if_en  out  1  PC / IF-to-ID advance enable
- id_en  out  1  IF/ID register load enable
- id_flush  out  1  IF/ID loads a NOP
- ex_flush  out  1  ID/EX loads a bubble
- trap_redirect  out  1  one-cycle pulse; PC loads the trap vector
- trap_epc  out  32  PC of the trapping instruction
- trap_busy  out  1  trap sequence in progress

## Operation
- Internal EX shadow: ex_v, ex_rd, ex_load. It is loaded from ID whenever ID/EX advances, i.e. not frozen and ex_flush is 0. When ex_flush is 1, ex_v is cleared.
- Load-use hazard: ex_v && ex_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2) && id_valid. Forwarding covers every other RAW case.
- FSM states (in package enum):
  - RUN
  - DRAIN: counter cnt of width 3
  - REDIRECT
- Per-cycle priority, highest first:
  1. reset
  2. dmem_wait: all enables 0, no flushes, FSM and cnt hold.
  3. ex_redirect: id_flush=1, ex_flush=1, if_en=1, id_en=1. Any trap sequence is abandoned and the FSM goes to RUN, because the illegal instruction was on the wrong path.
  4. FSM actions (below).
  5. Load-use: if_en=0, id_en=0, ex_flush=1 for exactly one cycle.
  6. Normal operation: if_en=1, id_en=1, no flushes.
- RUN with id_valid && id_ill:
  - capture trap_epc <= id_pc
  - if_en=0, id_en=0, ex_flush=1
  - if DRAIN_CYCLES > 1: cnt <= DRAIN_CYCLES-1 and go to DRAIN; otherwise go to REDIRECT.
- DRAIN: if_en=0, id_en=0, ex_flush=1. cnt decrements on each unfrozen cycle. When cnt==1 and the cycle is unfrozen, go to REDIRECT.
- REDIRECT: trap_redirect=1, if_en=1, id_en=1, id_flush=1, ex_flush=1, then go to RUN.
- trap_busy = (state != RUN).
- An illegal instruction has priority over a load-use stall on the same cycle.
- An illegal instruction is ignored when id_valid=0.

## Timing
- All outputs except trap_epc are combinational from state, shadow and inputs. trap_epc, FSM, cnt and shadow are registered.
- Reset, while asserted and on the following edge:
  - state=RUN, cnt=0, ex_v=0, trap_epc=0
  - outputs: if_en=0, id_en=0, id_flush=1, ex_flush=1, trap_redirect=0, trap_busy=0.
- Load-use latency: the stall is asserted in the same cycle the dependent instruction sits in ID. The next cycle proceeds normally because ex_v is now 0.
- Trap latency: from the ill cycle to the trap_redirect pulse is DRAIN_CYCLES unfrozen cycles. dmem_wait cycles extend it 1:1.
- dmem_wait together with ex_redirect: the freeze wins, and the redirect is applied on the first unfrozen cycle, with EX holding it stable.
- trap_epc is stable from capture until the next capture; it is not cleared on abandon.

## Structure
- Shared package pipe_pkg:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, IMM_OP, REG_OP), also used by the decoder
  - ctrl_state_t enum {RUN, DRAIN, REDIRECT}.
- Sub-module hazard_cmp: the combinational load-use comparator (ex_v, ex_load, ex_rd, rs1, rs2, id_valid) -> hazard.
- The FSM and EX shadow live in pipe_ctrl.

## Test plan
- Load-use: EX holds LOAD x5, ID holds ADD x6,x5,x1 -> one cycle with if_en=0, id_en=0, ex_flush=1, then normal; LOAD x0 followed by use of x0 -> no stall.
- Illegal instruction, DRAIN_CYCLES=2, id_pc=0x100 -> trap_busy rises, then trap_redirect=1 exactly 2 cycles after the ill cycle with trap_epc=0x100, then RUN.
- Same as above with dmem_wait high for 3 cycles during DRAIN -> trap_redirect is delayed by exactly 3 cycles.
- ex_redirect=1 in the first DRAIN cycle -> id_flush=1, ex_flush=1, FSM returns to RUN, trap_redirect never asserts.
- Load-use hazard and ex_redirect on the same cycle -> flush only (if_en=1, no stall); next cycle normal.
- Reset asserted mid-DRAIN -> on the next edge state=RUN, trap_epc=0, all outputs at their reset values.
